// File: rtl/uart_tx_cfg.sv
// UART transmitter with elaboration-time data width, parity and stop bits.
// One-entry holding register behind a valid/ready handshake allows gapless frames.
module uart_tx_cfg #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] CYC_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam bit          PAR_EN       = (PARITY == 1) || (PARITY == 2);
    localparam bit          PAR_ODD      = (PARITY == 1);
    localparam logic [3:0]  DATA_LAST    = 4'(DATA_BITS - 1);
    // Any STOP_BITS value other than 2 behaves as a single stop bit.
    localparam logic [3:0]  STOP_LAST    = (STOP_BITS == 2) ? 4'd1 : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] hold_data, hold_data_n;
    logic                 hold_full, hold_full_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic                 par_q, par_n;
    logic [3:0]           bit_idx, bit_n;
    logic [15:0]          cyc_cnt, cyc_n;
    logic                 tx_n, ready_n, busy_n, done_n;
    logic                 bit_end, load;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hold_data <= '0;
            hold_full <= 1'b0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_idx   <= 4'd0;
            cyc_cnt   <= 16'd0;
            tx        <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            hold_data <= hold_data_n;
            hold_full <= hold_full_n;
            shift_q   <= shift_n;
            par_q     <= par_n;
            bit_idx   <= bit_n;
            cyc_cnt   <= cyc_n;
            tx        <= tx_n;
            tx_ready  <= ready_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
        end
    end

    // Next-state, bit timing, handshake and line value.
    always_comb begin
        state_n     = state;
        hold_data_n = hold_data;
        hold_full_n = hold_full;
        shift_n     = shift_q;
        par_n       = par_q;
        bit_n       = bit_idx;
        cyc_n       = cyc_cnt;
        tx_n        = tx;
        done_n      = 1'b0;
        load        = 1'b0;
        bit_end     = (cyc_cnt == CYC_LAST);

        if (state != S_IDLE) begin
            cyc_n = bit_end ? 16'd0 : cyc_cnt + 16'd1;
        end

        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                load = hold_full;
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    bit_n   = 4'd0;
                    tx_n    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == DATA_LAST) begin
                        bit_n = 4'd0;
                        if (PAR_EN) begin
                            state_n = S_PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_idx + 4'd1;
                        shift_n = shift_q >> 1;
                        tx_n    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    bit_n   = 4'd0;
                    tx_n    = 1'b1;
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                        load    = hold_full;
                    end else begin
                        bit_n = bit_idx + 4'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
                cyc_n   = 16'd0;
                bit_n   = 4'd0;
            end
        endcase

        // Move the held word into the shifter and begin the start bit.
        if (load) begin
            state_n     = S_START;
            tx_n        = 1'b0;
            shift_n     = hold_data;
            par_n       = (^hold_data) ^ PAR_ODD;
            hold_full_n = 1'b0;
            cyc_n       = 16'd0;
            bit_n       = 4'd0;
        end

        // tx_ready mirrors an empty register, so accept never collides with load.
        if (tx_valid && tx_ready) begin
            hold_data_n = tx_data;
            hold_full_n = 1'b1;
        end

        ready_n = !hold_full_n;
        busy_n  = (state_n != S_IDLE);
    end

endmodule
